// File: rtl/jtsbaskt_pkg.sv
// Shared constants for the Super Basketball colour PROM path.
package jtsbaskt_pkg;
  localparam logic [21:0] PROM_START_DEF = 22'h1_0000;
  localparam int          PROM_LEN_DEF   = 768;

  localparam int RED   = 0;
  localparam int GREEN = 1;
  localparam int BLUE  = 2;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_st_t;
endpackage

// File: rtl/jtsbaskt_vblank_latch.sv
// Frame-synchronous register: CPU writes are held pending and applied on the LVBL falling edge.
module jtsbaskt_vblank_latch #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] din,
  input  logic         lvbl,
  output logic [W-1:0] dout
);
  logic         lvbl_l, pend;
  logic [W-1:0] pend_val;
  logic         vb_fall;

  // Reset value 0 so a low LVBL at reset release is not seen as an edge
  assign vb_fall = lvbl_l & ~lvbl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvbl_l   <= 1'b0;
      pend     <= 1'b0;
      pend_val <= '0;
      dout     <= '0;
    end else begin
      lvbl_l <= lvbl;
      if (vb_fall) begin
        if (we)        dout <= din;
        else if (pend) dout <= pend_val;
        pend <= 1'b0;
      end else if (we) begin
        pend_val <= din;
        pend     <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/jtsbaskt_pal_ctrl.sv
// Colour PROM download router, load-complete flag and vblank-synchronised palette bank.
module jtsbaskt_pal_ctrl
  import jtsbaskt_pkg::*;
#(
  parameter logic [21:0] PROM_START = PROM_START_DEF,
  parameter int          PROM_LEN   = PROM_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  input  logic        cpu_pal_we,
  input  logic [3:0]  cpu_dout,
  input  logic        LVBL,
  output logic [7:0]  prog_addr,
  output logic [3:0]  prog_data,
  output logic [2:0]  prog_en,
  output logic        prom_ok,
  output logic [3:0]  pal_sel
);
  localparam logic [9:0] LEN10 = 10'(PROM_LEN);

  ld_st_t      st, st_nx;
  logic        dl_l, dl_rise, dl_fall;
  logic [21:0] off;
  logic        in_range, accept;
  logic [9:0]  cnt;
  logic [2:0]  en_dec;
  logic        dout_unused;

  assign dout_unused = ^ioctl_dout[7:4];
  assign dl_rise     = downloading & ~dl_l;
  assign dl_fall     = ~downloading & dl_l;
  assign off         = ioctl_addr - PROM_START;
  assign in_range    = (ioctl_addr >= PROM_START) && (off < 22'(PROM_LEN));
  assign accept      = (st == LOAD) && downloading && ioctl_wr && in_range;

  always_comb begin
    en_dec = '0;
    case (off[9:8])
      2'd0:    en_dec[RED]   = 1'b1;
      2'd1:    en_dec[GREEN] = 1'b1;
      2'd2:    en_dec[BLUE]  = 1'b1;
      default: en_dec = '0;
    endcase
  end

  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    if (dl_rise) st_nx = LOAD;
      LOAD:    if (dl_fall) st_nx = DONE;
      DONE:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_l      <= 1'b0;
      cnt       <= '0;
      prom_ok   <= 1'b0;
      prog_en   <= '0;
      prog_addr <= '0;
      prog_data <= '0;
    end else begin
      dl_l    <= downloading;
      prog_en <= '0;
      if (st == IDLE && dl_rise) begin
        cnt     <= '0;
        prom_ok <= 1'b0;
      end else begin
        if (accept && cnt != LEN10) cnt <= cnt + 10'd1;
        if (st == DONE) prom_ok <= (cnt == LEN10);
      end
      if (accept) begin
        prog_en   <= en_dec;
        prog_addr <= off[7:0];
        prog_data <= ioctl_dout[3:0];
      end
    end
  end

  jtsbaskt_vblank_latch #(.W(4)) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cpu_pal_we),
    .din   (cpu_dout),
    .lvbl  (LVBL),
    .dout  (pal_sel)
  );
endmodule

// File: tb/tb_jtsbaskt_pal_ctrl.sv
// Bench for jtsbaskt_pal_ctrl: vector table, directed load/palette sequences, random model checks.
module tb_jtsbaskt_pal_ctrl;
  logic        clk = 0, rst_n = 1, downloading = 0, ioctl_wr = 0, cpu_pal_we = 0, LVBL = 1;
  logic [21:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [3:0]  cpu_dout = '0;
  logic [7:0]  prog_addr;
  logic [3:0]  prog_data, pal_sel;
  logic [2:0]  prog_en;
  logic        prom_ok;

  int ntot = 0, npass = 0;
  int onehot_err = 0;
  int pulses [3];

  logic [2:0] g_en, g_en2;
  logic [7:0] g_addr;
  logic [3:0] g_data;

  logic [3:0] pq [$];
  logic [3:0] exp_pal = 4'h0;
  logic       m_lv = 1'b1;

  typedef struct {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [2:0]  en;
    logic [7:0]  pa;
    logic [3:0]  pd;
  } vec_t;
  vec_t vt [10];

  jtsbaskt_pal_ctrl dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .cpu_pal_we(cpu_pal_we),
    .cpu_dout(cpu_dout), .LVBL(LVBL), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_en(prog_en), .prom_ok(prom_ok), .pal_sel(pal_sel)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n) begin
    if ($countones(prog_en) > 1) onehot_err++;
    for (int b = 0; b < 3; b++) if (prog_en[b]) pulses[b]++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // called at a negedge; returns outputs one and two cycles after the strobe
  task automatic wb(input logic [21:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1;
    @(negedge clk);
    g_en = prog_en; g_addr = prog_addr; g_data = prog_data;
    ioctl_wr = 0;
    @(negedge clk);
    g_en2 = prog_en;
  endtask

  task automatic dl_start();
    downloading = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic dl_end();
    downloading = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_seq(input int n);
    for (int i = 0; i < n; i++) begin
      wb(22'h10000 + 22'(i), 8'(i & 15));
      if (i == 'h105) begin
        chk("byte105_en", 32'(g_en), 32'h2);
        chk("byte105_addr", 32'(g_addr), 32'h05);
        chk("byte105_data", 32'(g_data), 32'h5);
      end
    end
  endtask

  // palette model: writes since the last falling edge queue up; the newest is applied at the edge
  task automatic pstep(input logic we, input logic [3:0] d, input logic l);
    cpu_pal_we = we; cpu_dout = d; LVBL = l;
    if (m_lv && !l) begin
      if (we) pq.push_back(d);
      if (pq.size() > 0) exp_pal = pq[pq.size()-1];
      pq.delete();
    end else if (we) pq.push_back(d);
    m_lv = l;
    @(negedge clk);
    cpu_pal_we = 0;
  endtask

  task automatic rand_load(input int n);
    int ai, acc;
    logic in;
    logic [2:0] ee;
    logic [7:0] ea;
    logic [3:0] ed;
    logic [21:0] a;
    logic [7:0] d;
    int r;
    acc = 0; ea = 8'hFF; ed = 4'hF;
    dl_start();
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 22'h10000 + 22'($urandom_range(0, 767));
      else if (r == 7) a = 22'h0FFFF - 22'($urandom_range(0, 300));
      else if (r == 8) a = 22'h10300 + 22'($urandom_range(0, 300));
      else             a = 22'($urandom);
      d = 8'($urandom);
      ai = int'(a);
      in = (ai >= 65536) && (ai < 65536 + 768);
      ee = in ? 3'(1 << ((ai - 65536) / 256)) : 3'b000;
      if (in) begin acc++; ea = 8'((ai - 65536) % 256); ed = d[3:0]; end
      wb(a, d);
      chk("rnd_en", 32'(g_en), 32'(ee));
      chk("rnd_en_width", 32'(g_en2), 32'h0);
      chk("rnd_addr", 32'(g_addr), 32'(ea));
      chk("rnd_data", 32'(g_data), 32'(ed));
    end
    dl_end();
    chk("rnd_prom_ok", 32'(prom_ok), (acc >= 768) ? 32'h1 : 32'h0);
  endtask

  initial begin
    vt[0] = '{22'h10000, 8'hA3, 3'b001, 8'h00, 4'h3};
    vt[1] = '{22'h100FF, 8'h0F, 3'b001, 8'hFF, 4'hF};
    vt[2] = '{22'h10100, 8'h01, 3'b010, 8'h00, 4'h1};
    vt[3] = '{22'h10105, 8'h05, 3'b010, 8'h05, 4'h5};
    vt[4] = '{22'h10200, 8'h4C, 3'b100, 8'h00, 4'hC};
    vt[5] = '{22'h102FF, 8'h0E, 3'b100, 8'hFF, 4'hE};
    vt[6] = '{22'h0FFFF, 8'h07, 3'b000, 8'hFF, 4'hE};
    vt[7] = '{22'h10300, 8'h08, 3'b000, 8'hFF, 4'hE};
    vt[8] = '{22'h00000, 8'h09, 3'b000, 8'hFF, 4'hE};
    vt[9] = '{22'h3FFFFF, 8'h06, 3'b000, 8'hFF, 4'hE};

    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(prog_en), 0);
    chk("rst_addr", 32'(prog_addr), 0);
    chk("rst_data", 32'(prog_data), 0);
    chk("rst_ok", 32'(prom_ok), 0);
    chk("rst_pal", 32'(pal_sel), 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    dl_start();
    foreach (vt[i]) begin
      wb(vt[i].addr, vt[i].data);
      chk($sformatf("vec%0d_en", i), 32'(g_en), 32'(vt[i].en));
      chk($sformatf("vec%0d_en_width", i), 32'(g_en2), 0);
      chk($sformatf("vec%0d_addr", i), 32'(g_addr), 32'(vt[i].pa));
      chk($sformatf("vec%0d_data", i), 32'(g_data), 32'(vt[i].pd));
    end
    dl_end();
    chk("partial_ok", 32'(prom_ok), 0);

    wb(22'h10010, 8'h03);
    chk("idle_wr_en", 32'(g_en), 0);

    // 767 good bytes plus two just outside the region must not complete the load
    dl_start();
    load_seq(767);
    wb(22'h0FFFF, 8'h01);
    chk("below_en", 32'(g_en), 0);
    wb(22'h10300, 8'h01);
    chk("above_en", 32'(g_en), 0);
    dl_end();
    chk("767_ok", 32'(prom_ok), 0);

    for (int b = 0; b < 3; b++) pulses[b] = 0;
    dl_start();
    load_seq(768);
    dl_end();
    chk("full_red", pulses[0], 256);
    chk("full_green", pulses[1], 256);
    chk("full_blue", pulses[2], 256);
    chk("full_ok", 32'(prom_ok), 1);

    dl_start();
    load_seq(500);
    dl_end();
    chk("abort_ok", 32'(prom_ok), 0);
    dl_start();
    load_seq(768);
    dl_end();
    chk("reload_ok", 32'(prom_ok), 1);

    pstep(0, 0, 1); pstep(0, 0, 1);
    pstep(1, 4'h7, 1);
    chk("pal_hold", 32'(pal_sel), 0);
    pstep(0, 0, 1);
    chk("pal_hold2", 32'(pal_sel), 0);
    pstep(0, 0, 0);
    chk("pal_edge7", 32'(pal_sel), 4'h7);
    pstep(0, 0, 0); pstep(0, 0, 1);
    pstep(1, 4'h2, 1); pstep(1, 4'h9, 1); pstep(0, 0, 1);
    chk("pal_hold7", 32'(pal_sel), 4'h7);
    pstep(0, 0, 0);
    chk("pal_last9", 32'(pal_sel), 4'h9);
    pstep(0, 0, 1);
    pstep(1, 4'h3, 1);
    pstep(1, 4'hC, 0);
    chk("pal_same_edge", 32'(pal_sel), 4'hC);
    pstep(0, 0, 1); pstep(0, 0, 0);
    chk("pal_pend_clr", 32'(pal_sel), 4'hC);

    for (int i = 0; i < 400; i++) begin
      pstep(($urandom_range(0, 3) == 0), 4'($urandom), ($urandom_range(0, 5) == 0) ? ~LVBL : LVBL);
      chk("pal_rnd", 32'(pal_sel), 32'(exp_pal));
    end

    rand_load($urandom_range(400, 1100));
    chk("pal_vs_dl", 32'(pal_sel), 32'(exp_pal));

    dl_start();
    load_seq(300);
    #2 rst_n = 0;
    #1;
    chk("arst_en", 32'(prog_en), 0);
    chk("arst_addr", 32'(prog_addr), 0);
    chk("arst_data", 32'(prog_data), 0);
    chk("arst_ok", 32'(prom_ok), 0);
    chk("arst_pal", 32'(pal_sel), 0);
    downloading = 0;
    @(negedge clk);
    rst_n = 1;
    pq.delete(); exp_pal = 4'h0; m_lv = LVBL;
    repeat (3) @(negedge clk);
    chk("post_rst_ok", 32'(prom_ok), 0);
    dl_start();
    load_seq(768);
    dl_end();
    chk("post_rst_full_ok", 32'(prom_ok), 1);

    rand_load($urandom_range(400, 1100));
    chk("onehot", onehot_err, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
